// File: rtl/zoom_line_ram_if.sv
`default_nettype none
// ============================================================================
//  Module      : zoom_line_ram_if
//  Description : Write-stream, read-window and status signals of the ZOOM
//                multi-line circular buffer, with master/slave views.
//  Revision    : 1.0 - initial release
// ============================================================================
interface zoom_line_ram_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 11,
    parameter int LINES      = 4
);
    localparam int CNT_W = $clog2(LINES + 1);

    logic                  wr_en;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_line_end;
    logic                  wr_ready;
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] rd_col;
    logic                  rd_release;
    logic                  win_ready;
    logic [DATA_WIDTH-1:0] rd_data_top;
    logic [DATA_WIDTH-1:0] rd_data_bot;
    logic                  rd_valid;
    logic [CNT_W-1:0]      lines_avail;
    logic                  clr_err;
    logic [2:0]            err;

    modport master (
        output wr_en, wr_data, wr_line_end, rd_en, rd_col, rd_release, clr_err,
        input  wr_ready, win_ready, rd_data_top, rd_data_bot, rd_valid,
               lines_avail, err
    );

    modport slave (
        input  wr_en, wr_data, wr_line_end, rd_en, rd_col, rd_release, clr_err,
        output wr_ready, win_ready, rd_data_top, rd_data_bot, rd_valid,
               lines_avail, err
    );
endinterface
`default_nettype wire

// File: rtl/zoom_line_ram.sv
`default_nettype none
// ============================================================================
//  Module      : zoom_line_ram
//  Description : LINES-deep circular line buffer. Raster pixels are written
//                into the current write bank; the reader sees two adjacent
//                completed lines (top/bottom) at a requested column.
//  Revision    : 1.0 - initial release
// ============================================================================
module zoom_line_ram #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 11,
    parameter int LINES      = 4,
    parameter int OUTPUT_REG = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    zoom_line_ram_if.slave   bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int LW    = $clog2(LINES);
    localparam int CW    = $clog2(LINES + 1);

    localparam logic [ADDR_WIDTH-1:0] C_LAST_COL  = {ADDR_WIDTH{1'b1}};
    localparam logic [LW-1:0]         C_LAST_LINE = LW'(LINES - 1);
    localparam logic [CW-1:0]         C_LINES     = CW'(LINES);
    localparam logic [CW-1:0]         C_TWO       = CW'(2);

    logic [LW-1:0]         r_wr_line;
    logic [LW-1:0]         r_rd_line;
    logic [ADDR_WIDTH-1:0] r_wr_col;
    logic                  r_col_full;
    logic [CW-1:0]         r_count;
    logic [2:0]            r_err;
    logic                  r_rd_v1;
    logic [LW-1:0]         r_top_sel;
    logic [LW-1:0]         r_bot_sel;

    logic                  w_wr_ready;
    logic                  w_win_ready;
    logic                  w_wr_acc;
    logic                  w_wr_store;
    logic                  w_end_acc;
    logic                  w_rel_acc;
    logic                  w_rd_acc;
    logic [LW-1:0]         w_bot_line;
    logic [LW-1:0]         w_wr_line_nxt;
    logic [LW-1:0]         w_rd_line_nxt;
    logic [2:0]            w_err_set;
    logic [2:0]            w_err_next;
    logic [LINES-1:0][DATA_WIDTH-1:0] w_bank_q;
    logic [DATA_WIDTH-1:0] w_top_q;
    logic [DATA_WIDTH-1:0] w_bot_q;

    assign w_wr_ready    = (r_count != C_LINES);
    assign w_win_ready   = (r_count >= C_TWO);
    assign w_wr_acc      = bus.wr_en && w_wr_ready;
    // The last column stays written once; later pixels of that line are dropped.
    assign w_wr_store    = w_wr_acc && !r_col_full;
    assign w_end_acc     = bus.wr_line_end && w_wr_ready;
    assign w_rel_acc     = bus.rd_release && (r_count != '0);
    assign w_rd_acc      = bus.rd_en && w_win_ready;
    assign w_bot_line    = (r_rd_line == C_LAST_LINE) ? '0 : r_rd_line + 1'b1;
    assign w_wr_line_nxt = (r_wr_line == C_LAST_LINE) ? '0 : r_wr_line + 1'b1;
    assign w_rd_line_nxt = w_bot_line;

    // Sticky error bits: a new event wins over a clear in the same cycle.
    always_comb begin
        w_err_set  = 3'b000;
        w_err_next = r_err;
        w_err_set[0] = (bus.wr_en || bus.wr_line_end) && !w_wr_ready;
        w_err_set[1] = bus.rd_en && !w_win_ready;
        w_err_set[2] = w_wr_acc && r_col_full;
        w_err_next   = (bus.clr_err ? 3'b000 : r_err) | w_err_set;
    end

    // Pointers, occupancy count, write column, errors and read-issue stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_line  <= '0;
            r_rd_line  <= '0;
            r_wr_col   <= '0;
            r_col_full <= 1'b0;
            r_count    <= '0;
            r_err      <= 3'b000;
            r_rd_v1    <= 1'b0;
            r_top_sel  <= '0;
            r_bot_sel  <= '0;
        end else begin
            r_err   <= w_err_next;
            r_rd_v1 <= w_rd_acc;
            if (w_rd_acc) begin
                // Bank select travels with the address so a release right
                // after issue cannot retarget an in-flight read.
                r_top_sel <= r_rd_line;
                r_bot_sel <= w_bot_line;
            end
            if (w_wr_store) begin
                if (r_wr_col == C_LAST_COL) begin
                    r_col_full <= 1'b1;
                end else begin
                    r_wr_col <= r_wr_col + 1'b1;
                end
            end
            if (w_end_acc) begin
                r_wr_line  <= w_wr_line_nxt;
                r_wr_col   <= '0;
                r_col_full <= 1'b0;
            end
            if (w_rel_acc) begin
                r_rd_line <= w_rd_line_nxt;
            end
            case ({w_end_acc, w_rel_acc})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    for (genvar b = 0; b < LINES; b++) begin : g_bank
        logic [DATA_WIDTH-1:0] r_mem [DEPTH];
        logic [DATA_WIDTH-1:0] r_q;

        // One write and one synchronous read port per bank; only window
        // banks are read, and the write bank is never a window bank.
        always_ff @(posedge clk) begin
            if (w_wr_store && (r_wr_line == LW'(b))) begin
                r_mem[r_wr_col] <= bus.wr_data;
            end
            if (w_rd_acc && ((r_rd_line == LW'(b)) || (w_bot_line == LW'(b)))) begin
                r_q <= r_mem[bus.rd_col];
            end
        end

        assign w_bank_q[b] = r_q;
    end

    assign w_top_q = w_bank_q[r_top_sel];
    assign w_bot_q = w_bank_q[r_bot_sel];

    if (OUTPUT_REG != 0) begin : g_oreg
        logic                  r_rd_valid;
        logic [DATA_WIDTH-1:0] r_data_top;
        logic [DATA_WIDTH-1:0] r_data_bot;

        // Output register stage; data holds between valid cycles.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_rd_valid <= 1'b0;
                r_data_top <= '0;
                r_data_bot <= '0;
            end else begin
                r_rd_valid <= r_rd_v1;
                if (r_rd_v1) begin
                    r_data_top <= w_top_q;
                    r_data_bot <= w_bot_q;
                end
            end
        end

        assign bus.rd_valid    = r_rd_valid;
        assign bus.rd_data_top = r_data_top;
        assign bus.rd_data_bot = r_data_bot;
    end else begin : g_no_oreg
        logic r_have_data;

        // RAM read registers are not reset, so mask them to zero until the
        // first read has landed; they only change on a read, so data holds.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_have_data <= 1'b0;
            end else if (r_rd_v1) begin
                r_have_data <= 1'b1;
            end
        end

        assign bus.rd_valid    = r_rd_v1;
        assign bus.rd_data_top = r_have_data ? w_top_q : '0;
        assign bus.rd_data_bot = r_have_data ? w_bot_q : '0;
    end

    assign bus.wr_ready    = w_wr_ready;
    assign bus.win_ready   = w_win_ready;
    assign bus.lines_avail = r_count;
    assign bus.err         = r_err;

endmodule
`default_nettype wire

// File: tb/tb_zoom_line_ram.sv
`default_nettype none
// ============================================================================
//  Module      : tb_zoom_line_ram
//  Description : Self-checking bench for zoom_line_ram. Read results are
//                predicted when rd_en is driven and compared on rd_valid.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_zoom_line_ram;
    localparam int DW = 16;
    localparam int AW = 9;
    localparam int NL = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    zoom_line_ram_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LINES(NL)) bus ();

    zoom_line_ram #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .LINES      (NL),
        .OUTPUT_REG (1)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int rd_gl = 0;       // global index of the current top line
    int wr_gl = 0;       // global index of the line being written
    int run = 0;
    int maxrun = 0;
    logic [2*DW-1:0] sb[$];

    function automatic logic [DW-1:0] pix(input int n, input int c);
        return DW'(n * 16 + c);
    endfunction

    // Advance one clock; sample #1 after the edge and score any read result.
    task automatic step();
        logic [2*DW-1:0] exp;
        @(posedge clk);
        #1;
        if (bus.rd_valid) begin
            run++;
            if (run > maxrun) maxrun = run;
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_rd_valid: got top=%h bot=%h, required no rd_valid",
                         bus.rd_data_top, bus.rd_data_bot);
            end else begin
                exp = sb.pop_front();
                if ({bus.rd_data_top, bus.rd_data_bot} !== exp) begin
                    miscompares++;
                    $display("FAIL read_data: got top=%h bot=%h, required top=%h bot=%h",
                             bus.rd_data_top, bus.rd_data_bot, exp[2*DW-1:DW], exp[DW-1:0]);
                end
            end
        end else begin
            run = 0;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 8 && sb.size() != 0; i++) step();
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL drain_timeout: got %0d reads outstanding, required 0", sb.size());
        end
        sb.delete();
    endtask

    task automatic do_reset();
        bus.wr_en = 0; bus.wr_data = '0; bus.wr_line_end = 0;
        bus.rd_en = 0; bus.rd_col = '0; bus.rd_release = 0; bus.clr_err = 0;
        rst_n = 0;
        sb.delete();
        rd_gl = 0;
        wr_gl = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
    endtask

    task automatic write_pixels(input int n, input int len);
        for (int c = 0; c < len; c++) begin
            bus.wr_en = 1;
            bus.wr_data = pix(n, c);
            step();
        end
        bus.wr_en = 0;
    endtask

    task automatic write_line(input int len);
        write_pixels(wr_gl, len);
        bus.wr_line_end = 1;
        step();
        bus.wr_line_end = 0;
        wr_gl++;
    endtask

    task automatic rd(input int col);
        bus.rd_en = 1;
        bus.rd_col = AW'(col);
        sb.push_back({pix(rd_gl, col), pix(rd_gl + 1, col)});
        step();
        bus.rd_en = 0;
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if (bus.wr_ready !== 1'b1 || bus.win_ready !== 1'b0 || bus.rd_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_flags: got wr_ready=%b win_ready=%b rd_valid=%b, required 1 0 0",
                     bus.wr_ready, bus.win_ready, bus.rd_valid);
        end
        vectors++;
        if (bus.lines_avail !== 3'd0 || bus.err !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_count_err: got lines_avail=%0d err=%b, required 0 000",
                     bus.lines_avail, bus.err);
        end
        vectors++;
        if (bus.rd_data_top !== '0 || bus.rd_data_bot !== '0) begin
            miscompares++;
            $display("FAIL reset_data: got top=%h bot=%h, required 0000 0000",
                     bus.rd_data_top, bus.rd_data_bot);
        end
    endtask

    task automatic test_fill_read();
        for (int l = 0; l < 4; l++) write_line(8);
        vectors++;
        if (bus.lines_avail !== 3'd4 || bus.wr_ready !== 1'b0 || bus.win_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL full_state: got lines_avail=%0d wr_ready=%b win_ready=%b, required 4 0 1",
                     bus.lines_avail, bus.wr_ready, bus.win_ready);
        end
        bus.rd_en = 1;
        bus.rd_col = AW'(3);
        sb.push_back({16'h0003, 16'h0013});
        step();
        bus.rd_en = 0;
        vectors++;
        if (bus.rd_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL latency_early: got rd_valid=%b after 1 cycle, required 0", bus.rd_valid);
        end
        step();
        vectors++;
        if (bus.rd_valid !== 1'b1 || sb.size() != 0) begin
            miscompares++;
            $display("FAIL latency_2: got rd_valid=%b pending=%0d after 2 cycles, required 1 0",
                     bus.rd_valid, sb.size());
        end
        step();
        vectors++;
        if (bus.rd_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL valid_pulse: got rd_valid=%b on 3rd cycle, required 0", bus.rd_valid);
        end
    endtask

    task automatic test_overflow();
        bus.wr_en = 1;
        bus.wr_data = 16'hFFFF;
        step();
        bus.wr_en = 0;
        vectors++;
        if (bus.err !== 3'b001) begin
            miscompares++;
            $display("FAIL overflow_err: got err=%b, required 001", bus.err);
        end
        bus.clr_err = 1;
        step();
        bus.clr_err = 0;
        vectors++;
        if (bus.err !== 3'b000) begin
            miscompares++;
            $display("FAIL clr_err: got err=%b, required 000", bus.err);
        end
        bus.rd_release = 1;
        step();
        bus.rd_release = 0;
        rd_gl++;
        vectors++;
        if (bus.lines_avail !== 3'd3 || bus.wr_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL release: got lines_avail=%0d wr_ready=%b, required 3 1",
                     bus.lines_avail, bus.wr_ready);
        end
        rd(3);   // expects top 0x0013, bot 0x0023
        drain();
    endtask

    task automatic test_underflow();
        do_reset();
        write_line(8);
        vectors++;
        if (bus.win_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL underflow_win: got win_ready=%b, required 0", bus.win_ready);
        end
        bus.rd_en = 1;
        bus.rd_col = AW'(0);
        step();
        bus.rd_en = 0;
        repeat (3) step();
        vectors++;
        if (bus.err !== 3'b010) begin
            miscompares++;
            $display("FAIL underflow_err: got err=%b, required 010", bus.err);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        write_line(8);
        write_line(8);
        for (int k = 0; k < 10; k++) begin
            write_pixels(wr_gl, 8);
            bus.wr_line_end = 1;
            bus.rd_release = 1;
            step();
            bus.wr_line_end = 0;
            bus.rd_release = 0;
            wr_gl++;
            rd_gl++;
            vectors++;
            if (bus.lines_avail !== 3'd2) begin
                miscompares++;
                $display("FAIL simul_end_release[%0d]: got lines_avail=%0d, required 2",
                         k, bus.lines_avail);
            end
            rd(k % 8);
            drain();
        end
    endtask

    task automatic test_upscale();
        for (int i = 0; i < 4; i++) rd(5);
        drain();
        maxrun = 0;
        for (int c = 0; c < 8; c++) rd(c);
        drain();
        vectors++;
        if (maxrun != 8) begin
            miscompares++;
            $display("FAIL pipelined_run: got %0d consecutive rd_valid, required 8", maxrun);
        end
    endtask

    task automatic test_downscale();
        bus.rd_release = 1;
        step();
        step();
        step();   // third release finds count==0 and is ignored
        bus.rd_release = 0;
        rd_gl += 2;
        vectors++;
        if (bus.lines_avail !== 3'd0 || bus.wr_ready !== 1'b1 || bus.win_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL downscale: got lines_avail=%0d wr_ready=%b win_ready=%b, required 0 1 0",
                     bus.lines_avail, bus.wr_ready, bus.win_ready);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        write_line(8);
        write_line(8);
        rd(0);
        rd(1);
        vectors++;
        if (bus.rd_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL pre_reset_valid: got rd_valid=%b, required 1", bus.rd_valid);
        end
        rst_n = 0;
        #1;
        vectors++;
        if (bus.rd_valid !== 1'b0 || bus.lines_avail !== 3'd0 || bus.wr_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL async_reset: got rd_valid=%b lines_avail=%0d wr_ready=%b, required 0 0 1",
                     bus.rd_valid, bus.lines_avail, bus.wr_ready);
        end
        sb.delete();
        @(negedge clk);
        rst_n = 1;
        rd_gl = 0;
        wr_gl = 0;
        repeat (3) step();   // discarded read must never surface
    endtask

    task automatic test_long_line();
        do_reset();
        for (int c = 0; c < 513; c++) begin
            bus.wr_en = 1;
            bus.wr_data = DW'(16'h8000 | c);
            step();
        end
        bus.wr_en = 0;
        vectors++;
        if (bus.err !== 3'b100) begin
            miscompares++;
            $display("FAIL long_line_err: got err=%b, required 100", bus.err);
        end
        bus.wr_line_end = 1;
        step();
        bus.wr_line_end = 0;
        for (int c = 0; c < 512; c++) begin
            bus.wr_en = 1;
            bus.wr_data = DW'(16'h4000 | c);
            step();
        end
        bus.wr_en = 0;
        bus.wr_line_end = 1;
        step();
        bus.wr_line_end = 0;
        bus.rd_en = 1;
        bus.rd_col = AW'(0);
        sb.push_back({16'h8000, 16'h4000});
        step();
        bus.rd_col = AW'(511);
        sb.push_back({16'h81FF, 16'h41FF});
        step();
        bus.rd_en = 0;
        drain();
    endtask

    initial begin
        test_reset();
        test_fill_read();
        test_overflow();
        test_underflow();
        test_wrap();
        test_upscale();
        test_downscale();
        test_reset_mid();
        test_long_line();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/zoom_line_ram.md
Name: zoom_line_ram

Overview:
- Parametrised multi-line circular buffer for the ZOOM scaler.
- Stores LINES video lines of up to 2^ADDR_WIDTH pixels, written as a raster stream.
- Presents two vertically adjacent lines (top/bottom) at a requested column for bilinear vertical interpolation.
- Tracks line occupancy with back-pressure and lets the reader re-read a line pair for upscaling; successor to the fixed 2048x16 single-port matrix RAM.

Parameters:
- DATA_WIDTH, 16, pixel width in bits (1..64).
- ADDR_WIDTH, 11, column address width; max line length 2^ADDR_WIDTH (9..13).
- LINES, 4, number of line banks (3..8).
- OUTPUT_REG, 1, extra output register stage on read data (0/1).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- wr_en  in  1  write pixel strobe.
- wr_data  in  DATA_WIDTH  pixel to write.
- wr_line_end  in  1  pulse: current write line complete.
- wr_ready  out  1  a free bank is available for writing.
- rd_en  in  1  read request.
- rd_col  in  ADDR_WIDTH  column to read.
- rd_release  in  1  pulse: free the top line of the window.
- win_ready  out  1  two completed lines are available.
- rd_data_top  out  DATA_WIDTH  pixel from the top line.
- rd_data_bot  out  DATA_WIDTH  pixel from the bottom line.
- rd_valid  out  1  rd_data_top/bot are valid this cycle.
- lines_avail  out  $clog2(LINES+1)  number of completed, unreleased lines.
- clr_err  in  1  clears err.
- err  out  3  sticky: [0] write overflow, [1] read underflow, [2] line too long.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values: wr_line=0, rd_line=0, wr_col=0, count=0, wr_ready=1, win_ready=0, rd_valid=0, rd_data_*=0, err=0. RAM contents are not reset.
- Storage: LINES banks, each 2^ADDR_WIDTH x DATA_WIDTH, synchronous read. Inferred RAM, no vendor primitive.
- Accepted write: wr_en && wr_ready.
  - Writes bank[wr_line][wr_col], then wr_col++.
  - If wr_col == 2^ADDR_WIDTH-1 is already written, wr_col holds, further writes on that line are dropped, and err[2] is set.
- Line end: wr_line_end && wr_ready advances wr_line modulo LINES, clears wr_col to 0 and increments count.
  - wr_en in the same cycle is written to the old line first.
- Write gating: wr_ready = (count != LINES).
  - wr_en or wr_line_end while wr_ready=0 is ignored and sets err[0].
- Read window:
  - win_ready = (count >= 2).
  - Top bank = rd_line; bottom bank = (rd_line+1) mod LINES.
- Read latency:
  - rd_en && win_ready registers rd_col; data appears 1+OUTPUT_REG cycles later with rd_valid=1 for one cycle.
  - Back-to-back rd_en gives one result per cycle, fully pipelined.
  - rd_en with win_ready=0 is ignored (no rd_valid) and sets err[1].
- Release: rd_release && count>0 advances rd_line modulo LINES and decrements count.
  - rd_release with count==0 is ignored.
  - Reads already issued complete with the pre-release banks, because bank select is captured with the address.
- Simultaneous wr_line_end and rd_release: both pointers advance and count is unchanged.
- Collision: the write bank is never a window bank while wr_ready=1, so no read/write address conflict exists by construction.
- Upscale: the reader re-reads the same window any number of times before releasing.
- Downscale: the reader issues multiple rd_release pulses on consecutive cycles.
- rd_data_* hold their last value when rd_valid=0.
- clr_err clears err in the next cycle. An error event in the same cycle takes priority and keeps the bit set.
- Reset mid-operation: all pointers and flags return to reset values immediately; in-flight reads are discarded, with rd_valid=0 at once.

Test Plan:
- Write 4 lines of 8 pixels, line L pixel c = L*16+c, pulsing wr_line_end. Then rd_en at col 3 -> after 2 cycles (OUTPUT_REG=1) top=0x0003, bot=0x0013, rd_valid=1 for one cycle, lines_avail=4, wr_ready=0.
- From the full state, wr_en=1 -> data dropped, err=3'b001; clr_err -> err=0; rd_release -> lines_avail=3, wr_ready=1, next read col 3 gives top=0x0013, bot=0x0023.
- After reset, rd_en with one completed line -> no rd_valid, err[1]=1, win_ready=0.
- Same-cycle wr_line_end and rd_release with count=2 -> count stays 2, both pointers advance; window wraps modulo LINES correctly over 10 lines.
- Read col 5 four times without release -> identical top/bot each time; pipelined rd_en on 8 consecutive cycles -> 8 consecutive rd_valid cycles in column order.
- Assert rst_n low mid-read pipeline -> rd_valid=0 immediately, lines_avail=0, wr_ready=1; with ADDR_WIDTH=9, write 513 pixels on one line -> err[2]=1 and the 513th pixel is dropped.
